// File: rtl/seq_multiplier_param_if.sv
// ---------------------------------------------------------------------------
// seq_multiplier_param_if : request/response bundle for seq_multiplier_param
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface seq_multiplier_param_if #(
  parameter int WIDTH = 5
);
  logic                 start;
  logic                 signed_op;
  logic [WIDTH-1:0]     X;
  logic [WIDTH-1:0]     Y;
  logic [2*WIDTH-1:0]   result;
  logic                 busy;
  logic                 Done;

  modport master (
    output start, signed_op, X, Y,
    input  result, busy, Done
  );

  modport slave (
    input  start, signed_op, X, Y,
    output result, busy, Done
  );
endinterface

`default_nettype wire

// File: rtl/seq_multiplier_param.sv
// ---------------------------------------------------------------------------
// seq_multiplier_param : radix-2 Booth sequential multiplier, one step/cycle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_multiplier_param #(
  parameter int WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seq_multiplier_param_if.slave   bus
);

  localparam int              c_CW   = $clog2(WIDTH + 2);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [c_CW-1:0]      r_count;
  logic [WIDTH+1:0]     r_acc;
  logic [WIDTH+1:0]     r_mcand;
  logic [WIDTH:0]       r_mq;
  logic                 r_q1;
  logic [2*WIDTH-1:0]   r_result;

  logic                 w_busy;
  logic                 w_done;
  logic                 w_start_ok;
  logic                 w_last;
  logic [WIDTH:0]       w_x_ext;
  logic [WIDTH:0]       w_y_ext;
  logic [WIDTH+1:0]     w_sum;
  logic [WIDTH+1:0]     w_acc_nxt;
  logic [WIDTH:0]       w_mq_nxt;

  assign w_start_ok = bus.start && (r_state != c_CALC);
  assign w_last     = (r_state == c_CALC) && (r_count == c_LAST);

  assign w_x_ext = bus.signed_op ? {bus.X[WIDTH-1], bus.X} : {1'b0, bus.X};
  assign w_y_ext = bus.signed_op ? {bus.Y[WIDTH-1], bus.Y} : {1'b0, bus.Y};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (bus.start) w_state_nxt = c_CALC;
      c_CALC:  if (r_count == c_LAST) w_state_nxt = c_DONE;
      c_DONE:  if (bus.start) w_state_nxt = c_CALC;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      c_CALC:  w_busy = 1'b1;
      c_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  // Booth step: the pair {q0, q-1} selects add, subtract or hold, then the
  // combined acc/mq register shifts right arithmetically by one.
  always_comb begin
    case ({r_mq[0], r_q1})
      2'b01:   w_sum = r_acc + r_mcand;
      2'b10:   w_sum = r_acc - r_mcand;
      default: w_sum = r_acc;
    endcase
  end

  assign w_acc_nxt = {w_sum[WIDTH+1], w_sum[WIDTH+1:1]};
  assign w_mq_nxt  = {w_sum[0], r_mq[WIDTH:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mq     <= '0;
      r_q1     <= 1'b0;
      r_result <= '0;
    end else if (w_start_ok) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= {w_x_ext[WIDTH], w_x_ext};
      r_mq     <= w_y_ext;
      r_q1     <= 1'b0;
    end else if (r_state == c_CALC) begin
      r_count  <= r_count + c_CW'(1);
      r_acc    <= w_acc_nxt;
      r_mq     <= w_mq_nxt;
      r_q1     <= r_mq[0];
      // Low 2*WIDTH bits of the final {acc, mq} product
      if (w_last) begin
        r_result <= {w_acc_nxt[WIDTH-2:0], w_mq_nxt};
      end
    end
  end

  assign bus.busy   = w_busy;
  assign bus.Done   = w_done;
  assign bus.result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier_param.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier_param : scoreboard bench for WIDTH=5 and WIDTH=8 instances
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seq_multiplier_param;

  typedef struct {
    logic [15:0] res;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  exp_t q5[$];
  exp_t q8[$];

  seq_multiplier_param_if #(.WIDTH(5)) ifc5 ();
  seq_multiplier_param_if #(.WIDTH(8)) ifc8 ();

  seq_multiplier_param #(.WIDTH(5)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc5.slave)
  );

  seq_multiplier_param #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- WIDTH=5 monitor ----------------
  logic        pdone5;
  logic [9:0]  pres5;
  int          brun5;
  int          drise5;
  exp_t        e5;

  initial begin
    pdone5 = 1'b0; pres5 = '0; brun5 = 0; drise5 = 0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("w5_busy_done_exclusive", 32'(ifc5.busy & ifc5.Done), 32'd0);
      if (ifc5.busy) brun5++;
      if (ifc5.Done && !pdone5) begin
        drise5++;
        if (q5.size() == 0) begin
          check("w5_spurious_done", 32'd1, 32'd0);
        end else begin
          e5 = q5.pop_front();
          check("w5_result", 32'(ifc5.result), 32'(e5.res));
          check("w5_latency", 32'(cyc), 32'(e5.cyc));
          check("w5_busy_cycles", 32'(brun5), 32'd6);
        end
        brun5 = 0;
      end else if (ifc5.result !== pres5) begin
        check("w5_result_stable", 32'(ifc5.result), 32'(pres5));
      end
    end else begin
      brun5 = 0;
    end
    pdone5 = ifc5.Done;
    pres5  = ifc5.result;
  end

  // ---------------- WIDTH=8 monitor ----------------
  logic        pdone8;
  logic [15:0] pres8;
  int          brun8;
  exp_t        e8;

  initial begin
    pdone8 = 1'b0; pres8 = '0; brun8 = 0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("w8_busy_done_exclusive", 32'(ifc8.busy & ifc8.Done), 32'd0);
      if (ifc8.busy) brun8++;
      if (ifc8.Done && !pdone8) begin
        if (q8.size() == 0) begin
          check("w8_spurious_done", 32'd1, 32'd0);
        end else begin
          e8 = q8.pop_front();
          check("w8_result", 32'(ifc8.result), 32'(e8.res));
          check("w8_latency", 32'(cyc), 32'(e8.cyc));
          check("w8_busy_cycles", 32'(brun8), 32'd9);
        end
        brun8 = 0;
      end else if (ifc8.result !== pres8) begin
        check("w8_result_stable", 32'(ifc8.result), 32'(pres8));
      end
    end else begin
      brun8 = 0;
    end
    pdone8 = ifc8.Done;
    pres8  = ifc8.result;
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue5(input logic [4:0] x, input logic [4:0] y, input logic s,
                        input logic [9:0] exp);
    @(negedge clk);
    ifc5.X = x; ifc5.Y = y; ifc5.signed_op = s; ifc5.start = 1'b1;
    q5.push_back('{res: 16'(exp), cyc: cyc + 7});
    @(negedge clk);
    ifc5.start = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic s,
                        input logic [15:0] exp);
    @(negedge clk);
    ifc8.X = x; ifc8.Y = y; ifc8.signed_op = s; ifc8.start = 1'b1;
    q8.push_back('{res: exp, cyc: cyc + 10});
    @(negedge clk);
    ifc8.start = 1'b0;
  endtask

  task automatic wait_done5(input string name);
    int n;
    n = 0;
    while (!ifc5.Done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_done8(input string name);
    int n;
    n = 0;
    while (!ifc8.Done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  int d_before;

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    ifc5.start = 1'b0; ifc5.signed_op = 1'b0; ifc5.X = '0; ifc5.Y = '0;
    ifc8.start = 1'b0; ifc8.signed_op = 1'b0; ifc8.X = '0; ifc8.Y = '0;

    repeat (2) @(negedge clk);
    check("reset_result", 32'(ifc5.result), 32'd0);
    check("reset_busy",   32'(ifc5.busy),   32'd0);
    check("reset_done",   32'(ifc5.Done),   32'd0);
    #2 rst_n = 1'b1;

    // Unsigned and signed corners
    issue5(5'd31, 5'd31, 1'b0, 10'd961);   wait_done5("u31x31");
    issue5(5'h10, 5'h10, 1'b1, 10'h100);   wait_done5("sm16xm16");
    issue5(5'h10, 5'd15, 1'b1, 10'h310);   wait_done5("sm16x15");
    issue5(5'd0,  5'h1F, 1'b1, 10'd0);     wait_done5("s0xm1");
    issue5(5'd5,  5'h1D, 1'b1, 10'h3F1);   wait_done5("s5xm3");
    issue5(5'h10, 5'h1F, 1'b1, 10'd16);    wait_done5("sm16xm1");
    issue5(5'h10, 5'h1F, 1'b0, 10'd496);   wait_done5("u16x31");

    // Start held for 4 edges with operands changing mid-operation
    @(negedge clk);
    ifc5.X = 5'd3; ifc5.Y = 5'd5; ifc5.signed_op = 1'b0; ifc5.start = 1'b1;
    q5.push_back('{res: 16'd15, cyc: cyc + 7});
    @(negedge clk);
    ifc5.X = 5'd31; ifc5.Y = 5'd31; ifc5.signed_op = 1'b1;
    repeat (3) @(negedge clk);
    ifc5.start = 1'b0;
    wait_done5("held_start");

    // Reset three cycles into an operation aborts it
    @(negedge clk);
    ifc5.X = 5'd31; ifc5.Y = 5'd31; ifc5.signed_op = 1'b0; ifc5.start = 1'b1;
    @(negedge clk);
    ifc5.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_result", 32'(ifc5.result), 32'd0);
    check("abort_busy",   32'(ifc5.busy),   32'd0);
    check("abort_done",   32'(ifc5.Done),   32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    d_before = drise5;
    repeat (10) @(negedge clk);
    check("abort_no_done", 32'(drise5 - d_before), 32'd0);
    issue5(5'd7, 5'd9, 1'b0, 10'd63);      wait_done5("after_abort");

    // Back-to-back restart from DONE
    issue5(5'd10, 5'd3, 1'b0, 10'd30);     wait_done5("b2b_first");
    issue5(5'd2,  5'd2, 1'b0, 10'd4);
    check("b2b_done_fell",  32'(ifc5.Done),   32'd0);
    check("b2b_busy_rose",  32'(ifc5.busy),   32'd1);
    check("b2b_result_old", 32'(ifc5.result), 32'd30);
    wait_done5("b2b_second");

    // WIDTH=8 instance
    issue8(8'd255, 8'd255, 1'b0, 16'd65025); wait_done8("w8_u255x255");
    issue8(8'h80,  8'h80,  1'b1, 16'd16384); wait_done8("w8_sm128xm128");
    issue8(8'h80,  8'd2,   1'b0, 16'd256);   wait_done8("w8_u128x2");
    issue8(8'h80,  8'd127, 1'b1, 16'hC080);  wait_done8("w8_sm128x127");

    repeat (3) @(negedge clk);
    check("q5_drained", 32'(q5.size()), 32'd0);
    check("q8_drained", 32'(q8.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/seq_multiplier_param.md
SEQ_MULTIPLIER_PARAM -- requirements
Module: seq_multiplier_param

Interface
REQ-001 Parameter WIDTH, default 5, operand width in bits; legal range 2..32.
REQ-002 Port clk  input  1  rising-edge clock, single clock domain.
REQ-003 Port rst_n  input  1  asynchronous active-low reset.
REQ-004 Port start  input  1  operation request, sampled on rising clk.
REQ-005 Port signed_op  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 Port X  input  WIDTH  multiplicand, sampled with start.
REQ-007 Port Y  input  WIDTH  multiplier, sampled with start.
REQ-008 Port result  output  2*WIDTH  registered product.
REQ-009 Port busy  output  1  high while an operation is in progress.
REQ-010 Port Done  output  1  high while result holds a completed product.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-012 In IDLE or DONE, start=1 at a rising edge SHALL capture X, Y and signed_op, clear the accumulator and iteration counter, and enter CALC.
REQ-013 Algorithm: radix-2 Booth recoding over WIDTH+1-bit operands; unsigned operands are zero-extended and signed operands sign-extended to WIDTH+1 bits.
REQ-014 Each CALC cycle SHALL perform one Booth step (add, subtract or no-op, then arithmetic right shift of the combined accumulator/multiplier register).
REQ-015 CALC SHALL last exactly WIDTH+1 cycles; on the edge of the last step, result SHALL load the low 2*WIDTH bits of the final product and the FSM SHALL enter DONE.
REQ-016 Latency: Done SHALL rise WIDTH+1 rising edges after the edge that sampled start; it is fixed and independent of operand values.
REQ-017 busy SHALL be 1 exactly while in CALC; Done SHALL be 1 exactly while in DONE; busy and Done SHALL never both be 1.
REQ-018 result SHALL change only on entry to DONE and on reset; intermediate accumulator values SHALL never appear on result.
REQ-019 start asserted while in CALC SHALL be ignored, and the operation in progress SHALL complete unchanged.
REQ-020 X, Y and signed_op changing after the sampling edge SHALL NOT affect the operation in progress.
REQ-021 DONE SHALL be held, with result and Done stable, until start=1 restarts the FSM.
REQ-022 On restart from DONE, Done SHALL fall and busy SHALL rise on the same edge; result SHALL keep the previous product until the new one loads.
REQ-023 The product SHALL be exact modulo 2^(2*WIDTH): unsigned 0..(2^WIDTH-1)^2, signed including (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2).
REQ-024 The internal accumulator SHALL be WIDTH+2 bits wide so that subtracting the most-negative extended operand cannot overflow.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state IDLE, result=0, busy=0 and Done=0, and clear the counter and datapath registers.
REQ-026 Reset asserted during CALC SHALL abort the operation; no Done pulse or partial result SHALL appear after release.
REQ-027 After rst_n deasserts, the first rising edge with start=1 SHALL begin a normal operation.

Verification (WIDTH=5 unless stated)
REQ-028 Unsigned: X=31, Y=31, signed_op=0, 1-cycle start -> busy high for 6 cycles, then Done=1 and result=961 (0x3C1).
REQ-029 Signed: X=-16 (5'h10), Y=-16 -> result=256 (0x100); X=-16, Y=15 -> result=-240 (10'h310); X=0, Y=-1 -> result=0.
REQ-030 Start held high for 4 cycles during CALC with X and Y changed mid-operation -> original product delivered at the same latency, and no restart occurs.
REQ-031 rst_n pulsed low 3 cycles after start -> outputs are 0 immediately, Done stays 0 afterwards, and a subsequent 7*9 (unsigned) yields 63.
REQ-032 Back-to-back: start again while Done=1 -> Done falls the next edge, result stays at the old value until the new product loads 6 edges later.
REQ-033 WIDTH=8: 255*255 unsigned -> 65025 after 9 cycles; -128*-128 signed -> 16384.
